// File: rtl/onehot_event_decoder.sv
// ---------------------------------------------------------------------------
// onehot_event_decoder
//
// Purpose:
//   Sequential inverse of the 4-input priority encoder. It accepts an encoded
//   index plus the encoder's valid flag over a valid/ready handshake. It then
//   regenerates the matching one-hot strobe for HOLD cycles. Downstream logic
//   uses the strobe as a per-line enable, for example an interrupt ack or a
//   channel select. Back-to-back events follow each other with no idle cycle
//   between strobes.
//
// Parameters:
//   IDX_W  encoded index width; OUT_W = 2**IDX_W strobe lines
//   HOLD   cycles each strobe stays asserted (1..255)
//   CNT_W  width of each per-line event counter
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream offers an event
//   in_ready    block can accept this cycle (from state only)
//   in_code     encoded index
//   in_v        encoder valid flag; 0 = "no line active"
//   out_onehot  registered one-hot strobe
//   out_valid   registered, high while a strobe is driven
//   out_idx     registered copy of the strobed index
//   cnt_clr     synchronous clear of all event counters
//   evt_cnt     flattened per-line counters, line k at [k*CNT_W +: CNT_W]
//
// Build option:
//   ONEHOT_DEC_CNT_EN  when defined, builds saturating per-line event
//                      counters. When undefined, evt_cnt is tied to 0 and
//                      cnt_clr is ignored.
// ---------------------------------------------------------------------------
module onehot_event_decoder #(
  parameter int IDX_W = 2,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IDX_W-1:0]              in_code,
  input  logic                          in_v,
  output logic [(2**IDX_W)-1:0]         out_onehot,
  output logic                          out_valid,
  output logic [IDX_W-1:0]              out_idx,
  input  logic                          cnt_clr,
  output logic [(2**IDX_W)*CNT_W-1:0]   evt_cnt
);

  localparam int OUT_W = 2**IDX_W;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [7:0]        hold_cnt;
  logic [7:0]        hold_cnt_nx;
  logic [OUT_W-1:0]  onehot_nx;
  logic              valid_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic              accept;
  logic              accept_evt;

  function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] code);
    logic [OUT_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

  // in_ready depends only on state and reset, so it has no combinational
  // path from in_valid.
  assign in_ready   = rst_n && ((state == S_IDLE) || (hold_cnt == 8'd0));
  assign accept     = in_valid && in_ready;
  assign accept_evt = accept && in_v;

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    onehot_nx   = out_onehot;
    valid_nx    = out_valid;
    idx_nx      = out_idx;
    case (state)
      S_IDLE: begin
        // An event with in_v=0 is consumed here and produces nothing.
        if (accept_evt) begin
          state_nx    = S_HOLD;
          hold_cnt_nx = HOLD_LAST;
          onehot_nx   = decode(in_code);
          valid_nx    = 1'b1;
          idx_nx      = in_code;
        end
      end
      S_HOLD: begin
        if (hold_cnt != 8'd0) begin
          hold_cnt_nx = hold_cnt - 8'd1;
        end else if (accept_evt) begin
          // Reload in the last cycle so consecutive strobes abut, even
          // when the new index equals the current one.
          hold_cnt_nx = HOLD_LAST;
          onehot_nx   = decode(in_code);
          valid_nx    = 1'b1;
          idx_nx      = in_code;
        end else begin
          state_nx  = S_IDLE;
          onehot_nx = '0;
          valid_nx  = 1'b0;
          idx_nx    = '0;
        end
      end
      default: begin
        state_nx    = S_IDLE;
        hold_cnt_nx = 8'd0;
        onehot_nx   = '0;
        valid_nx    = 1'b0;
        idx_nx      = '0;
      end
    endcase
  end

  // ---- strobe register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hold_cnt   <= 8'd0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      out_onehot <= onehot_nx;
      out_valid  <= valid_nx;
      out_idx    <= idx_nx;
    end
  end

`ifdef ONEHOT_DEC_CNT_EN
  logic [CNT_W-1:0] cnt_q [OUT_W];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // ---- counter register stage ----
  // A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_W; k++) cnt_q[k] <= '0;
    end else if (cnt_clr) begin
      for (int k = 0; k < OUT_W; k++) cnt_q[k] <= '0;
    end else if (accept_evt) begin
      cnt_q[in_code] <= sat_inc(cnt_q[in_code]);
    end
  end

  for (genvar g = 0; g < OUT_W; g++) begin : g_cnt
    assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: doc/onehot_event_decoder.md
# onehot_event_decoder

- Sequential inverse of the team's 4-input priority encoder: accepts an encoded index plus encoder-valid flag over a valid/ready handshake.
- Drives the corresponding one-hot strobe for a programmable number of cycles.
- Sits downstream of encoders to regenerate per-line enables (interrupt acks, channel selects) from compact index buses.
- Back-to-back events are supported with no bubble between strobes.

## Interface
- `IDX_W`, default 2: encoded index width; derived `OUT_W = 2**IDX_W` (localparam).
- `HOLD`, default 1: cycles each strobe stays asserted; legal 1..255.
- `CNT_W`, default 8: width of each per-line event counter (counter feature only).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream offers an event.
- `in_ready` output 1: block can accept this cycle.
- `in_code` input `IDX_W`: encoded index (encoder Y).
- `in_v` input 1: encoder V flag; 0 means "no line active".
- `out_onehot` output `OUT_W`: registered one-hot strobe, bit `in_code` set.
- `out_valid` output 1: registered; high while a strobe is driven.
- `out_idx` output `IDX_W`: registered copy of the strobed index.
- `cnt_clr` input 1: synchronous clear of all event counters.
- `evt_cnt` output `OUT_W*CNT_W`: flattened per-line counters; line k at bits `[k*CNT_W +: CNT_W]`.

## Operation
- FSM states: IDLE, HOLD; 8-bit `hold_cnt`.
- Accept occurs when `in_valid && in_ready`.
- `in_ready` is combinational from state only, never from `in_valid`:
  - IDLE: 1.
  - HOLD: `hold_cnt == 0`.
  - 0 while `rst_n` low.
- Accept with `in_v=1`:
  - Next cycle `out_onehot = 1 << in_code`, `out_valid=1`, `out_idx=in_code`, `hold_cnt = HOLD-1`.
  - State becomes HOLD.
- Accept with `in_v=0`: event consumed, no strobe, counters unchanged.
  - From IDLE: stays IDLE.
  - From HOLD: treated as no accept (see last HOLD cycle).
- HOLD, `hold_cnt != 0`: decrement; outputs stable; `in_valid` ignored.
- HOLD, `hold_cnt == 0` (last cycle):
  - Accept with `in_v=1`: reload strobe for the new index, `hold_cnt=HOLD-1`, stay in HOLD. No zero cycle between strobes, even for the same index.
  - Otherwise: next cycle clears `out_onehot`, `out_valid`, `out_idx` to 0 and goes to IDLE.
- `out_onehot` is always zero or exactly one-hot; `out_valid == |out_onehot`.
- `in_code` values are all legal; there is no out-of-range case because `OUT_W = 2**IDX_W`.

## Timing
- Reset values: `out_onehot=0`, `out_valid=0`, `out_idx=0`, state IDLE, `hold_cnt=0`, all `evt_cnt=0`.
- Reset asserted mid-HOLD clears all outputs immediately (asynchronously). First accept is possible on the first clock edge with `rst_n` high.
- Latency: accept edge N → strobe visible after edge N, high for exactly `HOLD` cycles.
- Throughput: one strobe per `HOLD` cycles, sustained.
- `in_ready` timing: it falls the cycle after an accept when `HOLD>1`, and rises in the last HOLD cycle.
- With `HOLD=1`, `in_ready` stays 1 continuously.

## Configuration
- Macro: `ONEHOT_DEC_CNT_EN`.
- Defined:
  - Each accepted `in_v=1` event increments `evt_cnt[in_code]` on the accept edge, saturating at `2**CNT_W-1`.
  - `cnt_clr` zeroes all counters; if an increment coincides with `cnt_clr`, the clear wins.
- Undefined:
  - Ports still present, `evt_cnt` tied 0, `cnt_clr` ignored, no counter flops.
  - Strobe behaviour is identical in both builds.

## Test plan
1. Reset, `HOLD=1`: check outputs 0 and `in_ready` 0 during reset. Then send codes 3,2,1,0 back-to-back with `in_v=1` → `out_onehot` 1000,0100,0010,0001 on consecutive cycles, `in_ready` constantly 1.
2. `HOLD=4`, send code 2 → `out_onehot=0100` for exactly 4 cycles, `in_ready` 0 for 3 cycles then 1. Keep `in_valid` held with code 1 → 0010 starts on the cycle immediately after, with no gap.
3. `in_v=0`, code 3, in IDLE → accepted, `out_valid` stays 0. Same event in the last HOLD cycle → strobe ends and the block returns to IDLE.
4. `HOLD=4`, assert `rst_n` low during the 2nd strobe cycle → `out_onehot`/`out_valid` drop to 0 without a clock edge. After release, code 1 → 0010 held for 4 cycles.
5. With `ONEHOT_DEC_CNT_EN`, `CNT_W=2`: send code 0 five times → `evt_cnt[0]` reads 1,2,3,3,3. Code 2 once → lane 2 = 1. `cnt_clr` together with an event → all counters 0.
6. Without `ONEHOT_DEC_CNT_EN`: repeat scenario 5 → `evt_cnt` stays 0; strobes identical to scenario 5.
